ternary_regfile_dump: RTL and testbench



---
 rtl/ternary_dump_pkg.sv | 32 +++
 rtl/ternary_chunk_shifter.sv | 46 ++++
 rtl/ternary_regfile_dump.sv | 132 +++++++++++++
 tb/tb_ternary_regfile_dump.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_dump_pkg.sv
// Shared types, default sizes and the trit-validity helper for the register-file dump reader.
// The T_* encodings mirror ternary_defs.vh; they are only defined here if that header was not seen first.
`ifndef T_ZERO
`define T_ZERO 2'b00
`endif
`ifndef T_POS_ONE
`define T_POS_ONE 2'b01
`endif
`ifndef T_NEG_ONE
`define T_NEG_ONE 2'b10
`endif

package ternary_dump_pkg;

  localparam int DEF_NUM_REGS    = 9;
  localparam int DEF_TRIT_WIDTH  = 27;
  localparam int DEF_CHUNK_TRITS = 9;
  localparam int BEATS           = DEF_TRIT_WIDTH / DEF_CHUNK_TRITS;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  // 2'b11 is the one code point that is not a trit.
  function automatic logic trit_is_valid(input logic [1:0] t);
    return (t == `T_ZERO) || (t == `T_POS_ONE) || (t == `T_NEG_ONE);
  endfunction

endpackage

// File: rtl/ternary_chunk_shifter.sv
// Shadow copy of one register word, shifted out one chunk per accepted beat,
// with the beat counter and its last-beat flag.
module ternary_chunk_shifter
  import ternary_dump_pkg::*;
#(
  parameter int TRIT_WIDTH  = DEF_TRIT_WIDTH,
  parameter int CHUNK_TRITS = DEF_CHUNK_TRITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [2*TRIT_WIDTH-1:0]  i_data,
  input  logic                     i_shift,
  output logic [2*CHUNK_TRITS-1:0] o_chunk,
  output logic [1:0]               o_beat,
  output logic                     o_beat_last
);

  localparam int CW       = 2 * CHUNK_TRITS;
  localparam int N_BEATS  = TRIT_WIDTH / CHUNK_TRITS;

  logic [2*TRIT_WIDTH-1:0] r_shadow;
  logic [1:0]              r_beat;
  logic                    w_beat_last;

  assign w_beat_last = (r_beat == 2'(N_BEATS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_beat   <= '0;
    end else if (i_load) begin
      r_shadow <= i_data;
      r_beat   <= '0;
    end else if (i_shift) begin
      r_shadow <= r_shadow >> CW;
      r_beat   <= w_beat_last ? 2'd0 : r_beat + 2'd1;
    end
  end

  assign o_chunk     = r_shadow[CW-1:0];
  assign o_beat      = r_beat;
  assign o_beat_last = w_beat_last;

endmodule

// File: rtl/ternary_regfile_dump.sv
// Walks R1..R(NUM_REGS-1) over the register-file debug port and streams each word as trit chunks.
// Optional trit-encoding check enabled by TRITDUMP_TRIT_CHECK_EN (ports exist either way).
module ternary_regfile_dump
  import ternary_dump_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int TRIT_WIDTH  = DEF_TRIT_WIDTH,
  parameter int CHUNK_TRITS = DEF_CHUNK_TRITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               dbg_reg_idx,
  input  logic [2*TRIT_WIDTH-1:0]  dbg_reg_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*CHUNK_TRITS-1:0] out_data,
  output logic [3:0]               out_reg_idx,
  output logic [1:0]               out_beat_idx,
  output logic                     out_last,
  output logic                     out_invalid,
  output logic                     invalid_seen
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [3:0]               r_idx;
  logic                     w_fire;
  logic                     w_load;
  logic                     w_shift;
  logic [2*CHUNK_TRITS-1:0] w_chunk;
  logic [1:0]               w_beat;
  logic                     w_beat_last;

  assign w_fire  = out_valid && out_ready;
  assign w_load  = (r_state == LOAD);
  assign w_shift = (r_state == SEND) && w_fire;

  ternary_chunk_shifter #(
    .TRIT_WIDTH  (TRIT_WIDTH),
    .CHUNK_TRITS (CHUNK_TRITS)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      (dbg_reg_data),
    .i_shift     (w_shift),
    .o_chunk     (w_chunk),
    .o_beat      (w_beat),
    .o_beat_last (w_beat_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:    if (start) r_idx <= 4'd1;
        SEND:    if (w_fire && w_beat_last && r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
        DONE:    r_idx <= '0;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next      = r_state;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    out_valid   = 1'b0;
    dbg_reg_idx = '0;
    out_last    = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        dbg_reg_idx = r_idx;
        w_next      = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (r_idx == LAST_IDX) && w_beat_last;
        if (w_fire && w_beat_last) w_next = (r_idx == LAST_IDX) ? DONE : LOAD;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign out_data     = w_chunk;
  assign out_reg_idx  = r_idx;
  assign out_beat_idx = w_beat;

`ifdef TRITDUMP_TRIT_CHECK_EN
  logic w_invalid;
  logic r_invalid_seen;

  always_comb begin
    w_invalid = 1'b0;
    for (int t = 0; t < CHUNK_TRITS; t++) begin
      if (!trit_is_valid(out_data[2*t +: 2])) w_invalid = 1'b1;
    end
  end

  // Sticky across the dump; a fresh accepted start begins a clean record.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_invalid_seen <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_invalid_seen <= 1'b0;
    end else if (w_fire && w_invalid) begin
      r_invalid_seen <= 1'b1;
    end
  end

  assign out_invalid  = w_invalid;
  assign invalid_seen = r_invalid_seen;
`else
  assign out_invalid  = 1'b0;
  assign invalid_seen = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_regfile_dump.sv
// Scoreboard bench for ternary_regfile_dump: expected beats queued at start, popped on each handshake.
module tb_ternary_regfile_dump;

  localparam int NUM_REGS = 9;
  localparam int TW       = 27;
  localparam int CT       = 9;
  localparam int BEATS    = 3;
  localparam int DW       = 2 * TW;
  localparam int CW       = 2 * CT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, out_valid, out_last, out_invalid, invalid_seen;
  logic          out_ready = 1'b1;
  logic [3:0]    dbg_reg_idx, out_reg_idx;
  logic [DW-1:0] dbg_reg_data;
  logic [CW-1:0] out_data;
  logic [1:0]    out_beat_idx;

  logic [DW-1:0] regs [NUM_REGS];

  typedef struct {
    logic [CW-1:0] data;
    logic [3:0]    ridx;
    logic [1:0]    beat;
    logic          last;
    logic          inv;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int n_stall = 0;
  int ready_mode = 0;
  logic mon_en = 1'b0;
  logic model_seen = 1'b0;

  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [CW-1:0] p_data;
  logic [3:0]    p_reg;
  logic [1:0]    p_beat;
  logic          p_last;

  assign dbg_reg_data = (dbg_reg_idx < NUM_REGS) ? regs[dbg_reg_idx] : '0;

  ternary_regfile_dump dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .dbg_reg_idx  (dbg_reg_idx),
    .dbg_reg_data (dbg_reg_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_reg_idx  (out_reg_idx),
    .out_beat_idx (out_beat_idx),
    .out_last     (out_last),
    .out_invalid  (out_invalid),
    .invalid_seen (invalid_seen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else                 out_ready = ~out_ready;
  end

  // Scoreboard consumer plus stall-stability and sticky-flag tracking.
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        n_cmp++;
        n_stall++;
        if (out_valid !== 1'b1 || out_data !== p_data || out_reg_idx !== p_reg ||
            out_beat_idx !== p_beat || out_last !== p_last) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b data=%h reg=%0d beat=%0d last=%0b, want v=1 data=%h reg=%0d beat=%0d last=%0b",
                   out_valid, out_data, out_reg_idx, out_beat_idx, out_last, p_data, p_reg, p_beat, p_last);
        end
      end
      n_cmp++;
      if (invalid_seen !== model_seen) begin
        n_bad++;
        $display("FAIL invalid_seen: got %0b want %0b", invalid_seen, model_seen);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got reg=%0d beat=%0d data=%h, want no beat", out_reg_idx, out_beat_idx, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.data || out_reg_idx !== mon_e.ridx || out_beat_idx !== mon_e.beat ||
              out_last !== mon_e.last || out_invalid !== mon_e.inv) begin
            n_bad++;
            $display("FAIL beat: got data=%h reg=%0d beat=%0d last=%0b inv=%0b, want data=%h reg=%0d beat=%0d last=%0b inv=%0b",
                     out_data, out_reg_idx, out_beat_idx, out_last, out_invalid,
                     mon_e.data, mon_e.ridx, mon_e.beat, mon_e.last, mon_e.inv);
          end
          model_seen = model_seen | mon_e.inv;
        end
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_data  = out_data;
      p_reg   = out_reg_idx;
      p_beat  = out_beat_idx;
      p_last  = out_last;
    end
  end

  task automatic set_regs_default();
    for (int r = 0; r < NUM_REGS; r++) regs[r] = '0;
    regs[1] = 54'h1;
    regs[8] = {27{2'b10}};
  endtask

  task automatic push_expected();
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int b = 0; b < BEATS; b++) begin
        beat_t e;
        e.data = regs[r][CW*b +: CW];
        e.ridx = 4'(r);
        e.beat = 2'(b);
        e.last = (r == NUM_REGS - 1) && (b == BEATS - 1);
        e.inv  = 1'b0;
`ifdef TRITDUMP_TRIT_CHECK_EN
        for (int t = 0; t < CT; t++) if (e.data[2*t +: 2] == 2'b11) e.inv = 1'b1;
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_seen = 1'b0;
  endtask

  // Observes one dump from cycle 1 (start was high in cycle 0); no comparisons here.
  task automatic run_dump(input int restart_reg, input bit write_r3, input logic [DW-1:0] r3_new,
                          output int first_valid, output int done_cycle, output int n_done,
                          output int idle_cycle, output int q_at_done);
    int  c = 0;
    bit  pulsed = 0;
    bit  armed = 0;
    bit  written = 0;
    first_valid = -1;
    done_cycle  = -1;
    n_done      = 0;
    idle_cycle  = -1;
    q_at_done   = -1;
    while (c < 300 && idle_cycle < 0) begin
      @(negedge clk);
      c++;
      if (pulsed && start) start = 1'b0;
      if (restart_reg > 0 && !pulsed && out_valid && out_reg_idx == 4'(restart_reg)) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (armed) begin
        regs[3] = r3_new;
        written = 1;
        armed   = 0;
      end
      if (write_r3 && !written && !armed && dbg_reg_idx == 4'd2) armed = 1;
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) begin
        n_done++;
        if (done_cycle < 0) begin
          done_cycle = c;
          q_at_done  = exp_q.size();
        end
      end
      if (n_done > 0 && !busy) idle_cycle = c;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid, out_last, out_invalid, invalid_seen} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy/done/valid/last/inv/seen=%b want 000000",
               {busy, done, out_valid, out_last, out_invalid, invalid_seen});
    end
    n_cmp++;
    if ({dbg_reg_idx, out_data, out_reg_idx, out_beat_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got dbg=%0d data=%h reg=%0d beat=%0d want all 0",
               dbg_reg_idx, out_data, out_reg_idx, out_beat_idx);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic_dump();
    int fv, dc, nd, ic, qd;
    set_regs_default();
    ready_mode = 0;
    mon_en = 1'b1;
    push_expected();
    start_pulse();
    run_dump(0, 0, '0, fv, dc, nd, ic, qd);
    n_cmp++;
    if (fv !== 2) begin n_bad++; $display("FAIL basic_first_valid: got cycle %0d want 2", fv); end
    n_cmp++;
    if (dc !== 33) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 33", dc); end
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    n_cmp++;
    if (ic !== 34) begin n_bad++; $display("FAIL basic_idle_cycle: got %0d want 34", ic); end
    n_cmp++;
    if (qd !== 0) begin n_bad++; $display("FAIL basic_beats_left: got %0d want 0", qd); end
  endtask

  task automatic test_backpressure();
    int fv, dc, nd, ic, qd;
    set_regs_default();
    n_stall = 0;
    ready_mode = 1;
    push_expected();
    start_pulse();
    run_dump(0, 0, '0, fv, dc, nd, ic, qd);
    ready_mode = 0;
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", nd); end
    n_cmp++;
    if (qd !== 0) begin n_bad++; $display("FAIL bp_beats_left_at_done: got %0d want 0", qd); end
    n_cmp++;
    if (n_stall < 1) begin n_bad++; $display("FAIL bp_stalls_seen: got %0d want >0", n_stall); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_restart_ignored();
    int fv, dc, nd, ic, qd;
    set_regs_default();
    push_expected();
    start_pulse();
    run_dump(4, 0, '0, fv, dc, nd, ic, qd);
    n_cmp++;
    if (nd !== 1 || dc !== 33) begin
      n_bad++;
      $display("FAIL restart_done: got count=%0d cycle=%0d want count=1 cycle=33", nd, dc);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL restart_queued: got busy=%0b left=%0d want busy=0 left=0", busy, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int fv, dc, nd, ic, qd;
    int c = 0;
    int n_done_after = 0;
    int n_valid_after = 0;
    set_regs_default();
    push_expected();
    start_pulse();
    do begin
      @(negedge clk);
      c++;
    end while (!(out_valid && out_reg_idx == 4'd5 && out_beat_idx == 2'd0) && c < 100);
    n_cmp++;
    if (c >= 100) begin n_bad++; $display("FAIL abort_reach_r5: got timeout want R5 beat 0"); end
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done, dbg_reg_idx} !== 7'b0) begin
      n_bad++;
      $display("FAIL abort_state: got valid=%0b busy=%0b done=%0b dbg=%0d want all 0",
               out_valid, busy, done, dbg_reg_idx);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    model_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done_after++;
      if (out_valid) n_valid_after++;
    end
    n_cmp++;
    if (n_done_after !== 0 || n_valid_after !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got done=%0d valid=%0d want 0 0", n_done_after, n_valid_after);
    end
    mon_en = 1'b1;
    push_expected();
    start_pulse();
    run_dump(0, 0, '0, fv, dc, nd, ic, qd);
    n_cmp++;
    if (dc !== 33 || nd !== 1 || qd !== 0) begin
      n_bad++;
      $display("FAIL abort_redump: got done=%0d count=%0d left=%0d want 33 1 0", dc, nd, qd);
    end
  endtask

  task automatic test_write_between();
    int fv, dc, nd, ic, qd;
    logic [DW-1:0] r3_new;
    set_regs_default();
    regs[2] = {9{6'b100100}};
    regs[3] = {27{2'b01}};
    r3_new  = {9{6'b011000}};
    regs[3] = r3_new;
    push_expected();
    regs[3] = {27{2'b01}};
    start_pulse();
    run_dump(0, 1, r3_new, fv, dc, nd, ic, qd);
    n_cmp++;
    if (dc !== 33 || qd !== 0) begin
      n_bad++;
      $display("FAIL write_done: got cycle=%0d left=%0d want 33 0", dc, qd);
    end
  endtask

  task automatic test_trit_check();
    int fv, dc, nd, ic, qd;
    logic exp_seen;
    set_regs_default();
    regs[6][21:20] = 2'b11;
`ifdef TRITDUMP_TRIT_CHECK_EN
    exp_seen = 1'b1;
`else
    exp_seen = 1'b0;
`endif
    push_expected();
    start_pulse();
    run_dump(0, 0, '0, fv, dc, nd, ic, qd);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (invalid_seen !== exp_seen) begin
      n_bad++;
      $display("FAIL trit_seen_sticky: got %0b want %0b", invalid_seen, exp_seen);
    end
    set_regs_default();
    push_expected();
    start_pulse();
    @(negedge clk);
    n_cmp++;
    if (invalid_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL trit_seen_clear: got %0b want 0", invalid_seen);
    end
    run_dump(0, 0, '0, fv, dc, nd, ic, qd);
    n_cmp++;
    if (qd !== 0) begin n_bad++; $display("FAIL trit_redump_left: got %0d want 0", qd); end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got time limit want end of tests");
    $fatal(1, "watchdog");
  end

  initial begin
    set_regs_default();
    test_reset();
    test_basic_dump();
    test_backpressure();
    test_restart_ignored();
    test_abort();
    test_write_between();
    test_trit_check();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL leftover_beats: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
